// File: rtl/mem_pkg.sv
// Data-memory responder package: FSM states, byte-enable encodings,
// read-latency bounds and the alignment helper used when
// MEM_MISALIGN_CHECK_EN is defined.
package mem_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [3:0] BE_NONE  = 4'b0000;
   localparam logic [3:0] BE_BYTE0 = 4'b0001;
   localparam logic [3:0] BE_BYTE1 = 4'b0010;
   localparam logic [3:0] BE_BYTE2 = 4'b0100;
   localparam logic [3:0] BE_BYTE3 = 4'b1000;
   localparam logic [3:0] BE_HALF0 = 4'b0011;
   localparam logic [3:0] BE_HALF1 = 4'b1100;
   localparam logic [3:0] BE_WORD  = 4'b1111;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 8;
   // Holds READ_LATENCY-2 for the largest legal latency.
   localparam int WAIT_CNT_W = 3;

   // Byte at any offset, halfword at offsets 0/2, word at offset 0, or no-op.
   function automatic logic be_aligned(input logic [3:0] be, input logic [1:0] a);
      logic ok;
      ok = (be == BE_NONE)
        || (be == (BE_BYTE0 << a))
        || ((a == 2'd0) && ((be == BE_HALF0) || (be == BE_WORD)))
        || ((a == 2'd2) && (be == BE_HALF1));
      return ok;
   endfunction
endpackage

// File: rtl/mem_types_pkg.sv
// Shared word and address types for the data-memory path.
package mem_types_pkg;
   typedef logic [31:0] data_t;
   typedef logic [31:0] addr_t;
endpackage

// File: rtl/dmem_byte_ram.sv
// Word array split into four byte lanes: per-lane write enables,
// synchronous write, combinational read at the same word index.
module dmem_byte_ram
   import mem_types_pkg::*;
#(
   parameter  int DEPTH_WORDS = 1024,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic [3:0]       lane_we,
   input  logic [IDX_W-1:0] idx,
   input  data_t            wdata,
   output data_t            rdata
);
   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];

      // Lane write; contents are intentionally never reset.
      always_ff @(posedge clk) begin
         if (lane_we[l]) mem[idx] <= wdata[8*l +: 8];
      end

      assign rdata[8*l +: 8] = mem[idx];
   end
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder with fixed read latency.
// Stores commit on the accept edge; every access returns the word as it
// was before the store. Define MEM_MISALIGN_CHECK_EN to fault byte
// enables that do not match the low address bits.
module data_mem_responder
   import mem_types_pkg::*;
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  addr_t      req_addr,
   input  logic       req_we,
   input  logic [3:0] req_be,
   input  data_t      req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output data_t      rsp_rdata,
   output logic       rsp_err
);
   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam int ADDR_W = $bits(addr_t);

   if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
      $error("data_mem_responder: READ_LATENCY out of range");
   end

   state_e                state;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  accept;
   logic                  in_range;
   logic                  misalign;
   logic                  fault;
   logic [3:0]            lane_we;
   data_t                 rd_word;

   assign req_ready = (state == IDLE) && reset_n;
   assign accept    = req_valid && req_ready;
   assign in_range  = (req_addr[ADDR_W-1:IDX_W+2] == '0);

`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign = !be_aligned(req_be, req_addr[1:0]);
`else
   // Low address bits play no part when lanes are taken as given.
   logic unused_addr_lo;
   assign unused_addr_lo = ^req_addr[1:0];
   assign misalign       = 1'b0;
`endif

   assign fault   = !in_range || misalign;
   assign lane_we = (accept && req_we && !fault) ? req_be : 4'b0000;

   dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .clk     (clk),
      .lane_we (lane_we),
      .idx     (req_addr[IDX_W+1:2]),
      .wdata   (req_wdata),
      .rdata   (rd_word)
   );

   // Control FSM; response data is captured at accept so it reflects pre-store contents.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rsp_rdata <= fault ? '0 : rd_word;
                  rsp_err   <= fault;
                  if (READ_LATENCY == 1) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= WAIT_CNT_W'(READ_LATENCY - 2);
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, hand-written hold and
// reset sequences, then randomized accesses against a word-array model.
module tb_data_mem_responder;
   localparam int DEPTH = 128;
   localparam int RL    = 3;
   localparam int LIMIT = 40;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl [DEPTH];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(RL)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_we    (req_we),
      .req_be    (req_be),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: word array, explicit list of legal lane patterns.
   function automatic bit be_legal(input logic [3:0] be, input logic [1:0] a);
      case (be)
         4'b0000: return 1'b1;
         4'b0001: return a == 2'd0;
         4'b0010: return a == 2'd1;
         4'b0100: return a == 2'd2;
         4'b1000: return a == 2'd3;
         4'b0011: return a == 2'd0;
         4'b1100: return a == 2'd2;
         4'b1111: return a == 2'd0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er);
      bit bad;
      int w;
      bad = (longint'(a) >= longint'(4 * DEPTH));
`ifdef MEM_MISALIGN_CHECK_EN
      if (!be_legal(be, a[1:0])) bad = 1'b1;
`endif
      if (bad) begin
         rd = 32'h0;
         er = 1'b1;
      end else begin
         w  = int'(a / 4);
         rd = mdl[w];
         er = 1'b0;
         if (we)
            for (int l = 0; l < 4; l++)
               if (be[l]) mdl[w][8*l +: 8] = wd[8*l +: 8];
      end
   endtask

   // One access from a negedge: wait ready, accept, measure latency, optionally hold rsp_ready low.
   task automatic txn(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                      input int hold, input bit poke,
                      output logic [31:0] rd, output logic er, output int lat, output bit to);
      int n;
      to = 1'b0;
      n  = 0;
      while (!req_ready && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         to = 1'b1;
         return;
      end
      req_valid = 1'b1; req_addr = a; req_we = we; req_be = be; req_wdata = wd;
      rsp_ready = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) begin
         to = 1'b1;
         return;
      end
      rd = rsp_rdata;
      er = rsp_err;
      for (int h = 0; h < hold; h++) begin
         if (poke) begin
            req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
            req_addr = a; req_wdata = 32'h5555_5555;
         end
         @(negedge clk);
         chk("hold valid", {31'b0, rsp_valid}, 32'd1);
         chk("hold rdata", rsp_rdata, rd);
         chk("hold err", {31'b0, rsp_err}, {31'b0, er});
         chk("hold req_ready", {31'b0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic exec(input string nm, input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input int hold, input bit poke,
                       input bit use_tbl, input logic [31:0] t_rd, input logic t_er);
      logic [31:0] m_rd, rd;
      logic        m_er, er;
      int          lat;
      bit          to;
      model_txn(a, we, be, wd, m_rd, m_er);
      txn(a, we, be, wd, hold, poke, rd, er, lat, to);
      if (to) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout waiting for handshake", nm);
         return;
      end
      chk({nm, " latency"}, lat, RL);
      chk({nm, " rdata"}, rd, use_tbl ? t_rd : m_rd);
      chk({nm, " err"}, {31'b0, er}, {31'b0, use_tbl ? t_er : m_er});
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          use_tbl;
      logic [31:0] exp_rd;
      logic        exp_er;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [31:0] a, wd, rd, m_rd;
      logic        er, m_er;
      int          lat;
      bit          to;

      vecs[0]  = '{32'h100, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0};
      vecs[1]  = '{32'h100, 1'b0, 4'b1111, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{32'h102, 1'b1, 4'b1100, 32'h1234_0000, 1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{32'h100, 1'b0, 4'b1111, 32'h0,         1'b1, 32'h1234_BEEF, 1'b0};
      vecs[4]  = '{32'h100, 1'b1, 4'b0000, 32'hFFFF_FFFF, 1'b1, 32'h1234_BEEF, 1'b0};
      vecs[5]  = '{32'h100, 1'b0, 4'b1111, 32'h0,         1'b1, 32'h1234_BEEF, 1'b0};
      vecs[6]  = '{32'h200, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b1};
      vecs[7]  = '{32'h200, 1'b0, 4'b1111, 32'h0,         1'b1, 32'h0, 1'b1};
      vecs[8]  = '{32'hFFFF_FFFC, 1'b0, 4'b1111, 32'h0,   1'b1, 32'h0, 1'b1};
`ifdef MEM_MISALIGN_CHECK_EN
      vecs[9]  = '{32'h101, 1'b1, 4'b0110, 32'h00AB_CD00, 1'b1, 32'h0, 1'b1};
      vecs[10] = '{32'h100, 1'b0, 4'b1111, 32'h0,         1'b1, 32'h1234_BEEF, 1'b0};
`else
      vecs[9]  = '{32'h101, 1'b1, 4'b0110, 32'h00AB_CD00, 1'b1, 32'h1234_BEEF, 1'b0};
      vecs[10] = '{32'h100, 1'b0, 4'b1111, 32'h0,         1'b1, 32'h12AB_CDEF, 1'b0};
`endif
      vecs[11] = '{32'h1FC, 1'b0, 4'b1111, 32'h0,         1'b0, 32'h0, 1'b0};

      reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
      req_be = '0; req_wdata = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      chk("reset rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("reset req_ready", {31'b0, req_ready}, 32'd0);
      reset_n = 1'b1;
      #1;
      chk("post-reset req_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);

      // Fill every word so the model knows the whole array.
      for (int i = 0; i < DEPTH; i++) begin
         wd = $urandom;
         model_txn(32'(i * 4), 1'b1, 4'hF, wd, m_rd, m_er);
         txn(32'(i * 4), 1'b1, 4'hF, wd, 0, 1'b0, rd, er, lat, to);
         if (to) begin
            $display("FAIL fill: timeout at word %0d", i);
            $fatal(1, "fill stalled");
         end
         if (i % 16 == 0) chk("fill err", {31'b0, er}, 32'd0);
      end

      foreach (vecs[i])
         exec($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata,
              0, 1'b0, vecs[i].use_tbl, vecs[i].exp_rd, vecs[i].exp_er);

      // Whole array unchanged by the out-of-range store.
      for (int i = 0; i < DEPTH; i++)
         exec($sformatf("sweep%0d", i), 32'(i * 4), 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0);

      // Response held 5 cycles while a store is attempted outside IDLE.
      exec("hold load", 32'h100, 1'b0, 4'hF, 32'h0, 5, 1'b1, 1'b0, 32'h0, 1'b0);
      exec("after hold", 32'h100, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0);

      // Reset while in WAIT: response dropped, store stays committed.
      if (!req_ready) @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h40; req_we = 1'b1; req_be = 4'hF; req_wdata = 32'hA5A5_0001;
      model_txn(32'h40, 1'b1, 4'hF, 32'hA5A5_0001, m_rd, m_er);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("wait rsp_valid", {31'b0, rsp_valid}, 32'd0);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid-reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("mid-reset req_ready", {31'b0, req_ready}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("released rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("released req_ready", {31'b0, req_ready}, 32'd1);
      exec("committed store", 32'h40, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0);

      // Randomized mix against the model.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) a = 32'(4 * DEPTH) + $urandom_range(0, 4000);
         else a = $urandom_range(0, 4 * DEPTH - 1);
         exec($sformatf("rand%0d", i), a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              $urandom, $urandom_range(0, 3), 1'b0, 1'b0, 32'h0, 1'b0);
      end

      for (int i = 0; i < DEPTH; i++)
         exec($sformatf("final%0d", i), 32'(i * 4), 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
